// File: rtl/dds_demodulator.sv
// Recovers one bit per SAMPLES_PER_BIT accepted samples from an ASK/FSK/BPSK/baseband waveform.
// Latency: bit_valid one clock after the final sample of a window. No backpressure; en low freezes all state.
module dds_demodulator #(
  parameter int unsigned SAMPLES_PER_BIT = 64,
  parameter int unsigned ASK_THRESH      = 512,
  parameter int unsigned FSK_ZC_THRESH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        sample_valid,
  input  logic [11:0] sample,
  input  logic [11:0] ref_sample,
  input  logic [1:0]  mod_sel,
  input  logic        sync_clr,
  output logic        bit_out,
  output logic        bit_valid,
  output logic [15:0] metric
);

  localparam logic [1:0] MODE_ASK  = 2'b00;
  localparam logic [1:0] MODE_FSK  = 2'b01;
  localparam logic [1:0] MODE_BPSK = 2'b10;
  localparam logic [1:0] MODE_BB   = 2'b11;

  localparam logic [15:0] LAST_CNT = 16'(SAMPLES_PER_BIT - 1);
  localparam logic [15:0] HALF_SPB = 16'(SAMPLES_PER_BIT / 2);
  localparam logic [15:0] ASK_T    = 16'(ASK_THRESH);
  localparam logic [15:0] FSK_T    = 16'(FSK_ZC_THRESH);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic        prev_sign_q, prev_sign_d;
  logic        have_prev_q, have_prev_d;
  logic [1:0]  mode_q, mode_d;
  logic        bit_out_q, bit_out_d;
  logic        bit_valid_q, bit_valid_d;
  logic [15:0] metric_q, metric_d;

  logic        accept;
  logic        win_start;
  logic        win_last;
  logic [1:0]  cur_mode;
  logic        s_neg;
  logic        r_neg;
  logic [11:0] neg_sample;
  logic [15:0] mag;
  logic [15:0] acc_new;
  logic        decision;

  // The first sample of a window already runs under the freshly latched mode.
  always_comb begin
    accept    = sample_valid & en;
    win_start = (cnt_q == 16'd0);
    win_last  = (cnt_q == LAST_CNT);
    cur_mode  = win_start ? mod_sel : mode_q;
    s_neg     = sample[11];
    r_neg     = ref_sample[11];
  end

  // |sample| with -2048 clamped to 2047 so the magnitude fits 11 bits.
  always_comb begin
    neg_sample = ~sample + 12'd1;
    if (!sample[11]) begin
      mag = {5'd0, sample[10:0]};
    end else if (neg_sample[11]) begin
      mag = 16'd2047;
    end else begin
      mag = {5'd0, neg_sample[10:0]};
    end
  end

  always_comb begin
    acc_new  = acc_q;
    decision = 1'b0;
    case (cur_mode)
      MODE_ASK: begin
        acc_new  = (mag > acc_q) ? mag : acc_q;
        decision = (acc_new > ASK_T);
      end
      MODE_FSK: begin
        acc_new  = acc_q + {15'd0, (have_prev_q && (s_neg != prev_sign_q))};
        decision = (acc_new >= FSK_T);
      end
      MODE_BPSK: begin
        acc_new  = acc_q + {15'd0, (s_neg == r_neg)};
        decision = (acc_new >= HALF_SPB);
      end
      default: begin
        acc_new  = acc_q + {15'd0, (!s_neg && (sample[10:0] != 11'd0))};
        decision = (acc_new > HALF_SPB);
      end
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prev_sign_d = prev_sign_q;
    have_prev_d = have_prev_q;
    mode_d      = mode_q;
    bit_out_d   = bit_out_q;
    metric_d    = metric_q;
    bit_valid_d = 1'b0;
    if (en && sync_clr) begin
      // Realignment wins over a coincident sample, which is dropped.
      cnt_d       = 16'd0;
      acc_d       = 16'd0;
      have_prev_d = 1'b0;
    end else if (accept) begin
      if (win_start) begin
        mode_d = mod_sel;
      end
      if (cur_mode == MODE_FSK) begin
        prev_sign_d = s_neg;
        have_prev_d = 1'b1;
      end
      if (win_last) begin
        metric_d    = acc_new;
        bit_out_d   = decision;
        bit_valid_d = 1'b1;
        cnt_d       = 16'd0;
        acc_d       = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
        acc_d = acc_new;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 16'd0;
      acc_q       <= 16'd0;
      prev_sign_q <= 1'b0;
      have_prev_q <= 1'b0;
      mode_q      <= MODE_ASK;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      metric_q    <= 16'd0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prev_sign_q <= prev_sign_d;
      have_prev_q <= have_prev_d;
      mode_q      <= mode_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      metric_q    <= metric_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign metric    = metric_q;

endmodule

// File: tb/tb_dds_demodulator.sv
// Scoreboard bench for dds_demodulator: a window-level reference model queues expected bits,
// a negedge monitor pops and checks them against every bit_valid pulse.
module tb_dds_demodulator;

  localparam int SPB   = 16;
  localparam int ASK_T = 512;
  localparam int FSK_T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = 12'd0;
  logic [11:0] ref_sample = 12'd0;
  logic [1:0]  mod_sel = 2'd0;
  logic        sync_clr = 1'b0;
  logic        bit_out;
  logic        bit_valid;
  logic [15:0] metric;

  int vectors = 0;
  int miscompares = 0;
  int neg_cnt = 0;

  typedef struct {
    int cyc;
    int metric;
    int bitv;
  } exp_t;
  exp_t exp_q[$];

  int held_metric = 0;
  int held_bit = 0;

  // Reference model: samples of the open window, plus the FSK sign carried between windows.
  int win_s[$];
  int win_r[$];
  int win_mode = 0;
  bit m_have_prev = 1'b0;
  bit m_prev_neg = 1'b0;

  dds_demodulator #(
    .SAMPLES_PER_BIT(SPB),
    .ASK_THRESH(ASK_T),
    .FSK_ZC_THRESH(FSK_T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sample_valid(sample_valid),
    .sample(sample),
    .ref_sample(ref_sample),
    .mod_sel(mod_sel),
    .sync_clr(sync_clr),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .metric(metric)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int sv12(input logic [11:0] x);
    logic signed [11:0] t;
    t = x;
    return int'(t);
  endfunction

  task automatic close_window();
    exp_t e;
    int m;
    int a;
    int b;
    m = 0;
    b = 0;
    case (win_mode)
      0: begin
        foreach (win_s[i]) begin
          a = (win_s[i] < 0) ? -win_s[i] : win_s[i];
          if (a > 2047) a = 2047;
          if (a > m) m = a;
        end
        b = (m > ASK_T) ? 1 : 0;
      end
      1: begin
        foreach (win_s[i]) begin
          if (m_have_prev && ((win_s[i] < 0) != m_prev_neg)) m++;
          m_prev_neg  = (win_s[i] < 0);
          m_have_prev = 1'b1;
        end
        b = (m >= FSK_T) ? 1 : 0;
      end
      2: begin
        foreach (win_s[i]) if ((win_s[i] < 0) == (win_r[i] < 0)) m++;
        b = (m >= SPB / 2) ? 1 : 0;
      end
      default: begin
        foreach (win_s[i]) if (win_s[i] > 0) m++;
        b = (m > SPB / 2) ? 1 : 0;
      end
    endcase
    e.cyc    = neg_cnt + 2;
    e.metric = m;
    e.bitv   = b;
    exp_q.push_back(e);
    win_s.delete();
    win_r.delete();
  endtask

  // Drive one cycle of inputs just after a rising edge and advance the model.
  task automatic put(input int s, input int r, input int ms, input bit v, input bit e, input bit sc);
    @(posedge clk);
    #1;
    sample       = 12'(s);
    ref_sample   = 12'(r);
    mod_sel      = 2'(ms);
    sample_valid = v;
    en           = e;
    sync_clr     = sc;
    if (e && sc) begin
      win_s.delete();
      win_r.delete();
      m_have_prev = 1'b0;
    end else if (e && v) begin
      if (win_s.size() == 0) win_mode = ms;
      win_s.push_back(sv12(12'(s)));
      win_r.push_back(sv12(12'(r)));
      if (win_s.size() == SPB) close_window();
    end
  endtask

  task automatic samp(input int s, input int r, input int ms);
    put(s, r, ms, 1'b1, 1'b1, 1'b0);
  endtask

  function automatic int rpos();
    return int'($urandom_range(0, 2047));
  endfunction

  function automatic int rneg();
    return -int'($urandom_range(1, 2048));
  endfunction

  function automatic int rnz();
    int v;
    v = int'($urandom_range(1, 2047));
    return ($urandom_range(0, 1) == 1) ? v : -v;
  endfunction

  // Monitor: every negedge, either match a bit_valid pulse to the queue or confirm outputs are holding.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (!reset) begin
        held_metric = 0;
        held_bit    = 0;
        exp_q.delete();
        chk("reset_bit_valid", int'(bit_valid), 0);
        chk("reset_metric", int'(metric), 0);
        chk("reset_bit_out", int'(bit_out), 0);
      end else if (bit_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("bit_valid_cycle", neg_cnt, e.cyc);
          chk("metric", int'(metric), e.metric);
          chk("bit_out", int'(bit_out), e.bitv);
          held_metric = e.metric;
          held_bit    = e.bitv;
        end
      end else begin
        chk("metric_hold", int'(metric), held_metric);
        chk("bit_out_hold", int'(bit_out), held_bit);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("por_metric", int'(metric), 0);
    chk("por_bit_valid", int'(bit_valid), 0);
    reset = 1'b1;

    // FSK: alternating signs, then sign flipping every 4 samples after a negative sample.
    for (int i = 0; i < SPB; i++) samp((i % 2 == 0) ? rpos() : rneg(), 0, 1);
    for (int i = 0; i < SPB; i++) samp(((i / 4) % 2 == 0) ? rpos() : rneg(), 0, 1);

    // ASK: strong carrier, weak carrier, window with full-scale negative.
    for (int i = 0; i < SPB; i++) samp((i % 2 == 0) ? 1000 : -1000, 0, 0);
    for (int i = 0; i < SPB; i++) samp((i % 2 == 0) ? 100 : -100, 0, 0);
    begin
      int pos;
      pos = int'($urandom_range(0, SPB - 1));
      for (int i = 0; i < SPB; i++) samp((i == pos) ? -2048 : int'($urandom_range(0, 1000)) - 500, 0, 0);
    end

    // BPSK: in-phase then anti-phase reference.
    for (int i = 0; i < SPB; i++) begin
      int v;
      v = rnz();
      samp(v, v, 2);
    end
    for (int i = 0; i < SPB; i++) begin
      int v;
      v = rnz();
      samp(v, -v, 2);
    end

    // Mode change mid-window takes effect only at the next window.
    for (int i = 0; i < SPB; i++) samp((i % 2 == 0) ? 1000 : -1000, 0, (i < 5) ? 0 : 1);
    for (int i = 0; i < SPB; i++) samp(rnz(), 0, 1);

    // en low for 10 cycles mid-window with sample_valid still asserted.
    for (int i = 0; i < 7; i++) samp(rnz(), 0, 3);
    for (int i = 0; i < 10; i++) put(rnz(), 0, 3, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i < SPB; i++) samp(rnz(), 0, 3);

    // sync_clr coincident with the sample at cnt=9.
    for (int i = 0; i < 9; i++) samp(rnz(), rnz(), 2);
    put(rnz(), rnz(), 2, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < SPB; i++) samp(rnz(), rnz(), 2);

    // Asynchronous reset mid-window.
    for (int i = 0; i < 6; i++) samp(rnz(), 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    sample_valid = 1'b0;
    #1;
    chk("async_bit_out", int'(bit_out), 0);
    chk("async_bit_valid", int'(bit_valid), 0);
    chk("async_metric", int'(metric), 0);
    win_s.delete();
    win_r.delete();
    m_have_prev = 1'b0;
    m_prev_neg  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < SPB; i++) samp(rnz(), 0, 3);

    // Randomised traffic: gaps, enable drops, occasional realignment, any mode.
    begin
      int ms;
      ms = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) ms = int'($urandom_range(0, 3));
        put(sv12(12'($urandom)), sv12(12'($urandom)), ms,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 59) == 0));
      end
    end

    for (int i = 0; i < 4; i++) put(0, 0, 0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("drain_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
